mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

- Sits directly downstream of the CPU core's cache refill/writeback ports.
- Accepts three pulse-started requests (I-cache line read, D-cache line read, D-cache line write) and serializes them onto a single 128-bit memory command port, one transaction at a time.
- Routes read beats and write responses back to the requesting cache, with fixed priority dcw > dcr > icr.

## Interface
Parameters:
- RBEATS, 1: 128-bit beats per read transaction (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- icr_start_rq  in  1  one-cycle I-cache read request pulse.
- ic_rin_addr  in  32  I-cache read byte address.
- ic_rdat_m_data  out  128  I-cache read beat.
- ic_rdat_m_mask  out  16  constant 16'hffff.
- ic_rdat_m_valid  out  1  I-cache beat valid.
- ic_finish_mrd  out  1  pulse with last I-cache beat.
- dcr_start_rq  in  1  D-cache read request pulse.
- dcr_rin_addr  in  32  D-cache read byte address.
- rdat_m_data  out  128  D-cache read beat.
- rdat_m_valid  out  1  D-cache beat valid.
- finish_mrd  out  1  pulse with last D-cache beat.
- dcw_start_rq  in  1  D-cache write request pulse.
- dcw_in_addr  in  32  write byte address.
- dcw_in_mask  in  16  byte enables; bit i=1 writes byte i.
- dcw_in_data  in  128  write data.
- dcw_finish_wresp  out  1  write-complete pulse.
- rqfull_1  out  1  data-side request queued, not yet granted.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  command accepted when valid&ready.
- mem_cmd_write  out  1  1=write, 0=read.
- mem_cmd_addr  out  28  line address [31:4].
- mem_wmask  out  16  write byte enables.
- mem_wdata  out  128  write data.
- mem_rdata  in  128  read beat.
- mem_rdata_valid  in  1  read beat valid.
- mem_wresp_valid  in  1  write response.

## Operation
- Three request slots (icr, dcr, dcw). Each captures address (plus mask/data for dcw) on its start pulse and sets pend_x. A pulse into an already-pending slot is a protocol error: it is ignored and flagged by a bench assertion.
- FSM states:
  - IDLE: if any pend_x, grant the highest-priority one, clear its pend, latch the command, go to CMD.
  - CMD: mem_cmd_valid=1 with fields held stable until mem_cmd_ready. Then go to RDATA (read) or WRESP (write).
  - RDATA: count mem_rdata_valid beats, 2-bit counter, and forward each to the granted source. On beat RBEATS, go to IDLE.
  - WRESP: on mem_wresp_valid, go to IDLE.
- A pulse arriving in the same cycle its slot is granted cannot happen, because pend must already be set; slots are independent of each other.
- Forwarding is registered: ic/rdat data+valid one cycle after mem_rdata_valid. finish_* asserts with the last beat's valid; dcw_finish_wresp one cycle after mem_wresp_valid.
- Memory read data/responses arriving while not in RDATA/WRESP are dropped.
- rqfull_1 = pend_dcr | pend_dcw.
- Address low bits [3:0] are discarded.

## Timing
- Reset values: all valids, finish pulses, mem_cmd_valid, mem_cmd_write and rqfull_1 are 0; data/addr/mask outputs are 0; ic_rdat_m_mask is 16'hffff; state IDLE; all pend cleared.
- Latency: start pulse sampled at edge N → pend at N+1 → mem_cmd_valid high from N+2.
- Back-to-back: after the last beat or response, IDLE grants a pending slot in the same cycle, so the next mem_cmd_valid appears 1 cycle after IDLE is entered.
- Reset mid-transaction returns to IDLE immediately and drops the in-flight transaction; no finish pulse is issued.
- The I side may starve under continuous D traffic; accepted because the D-cache is blocking.

## Structure
- Shared package/header holds the FSM state encodings (IDLE, CMD, RDATA, WRESP), source IDs (SRC_IC, SRC_DR, SRC_DW) and the line-offset width (4).
- One sub-module, arb_req_slot: a parameterized-width pulse-capture register with a pend flag, instantiated three times.
- The top holds the FSM, beat counter and return routing.

## Test plan
- icr pulse, addr 0x0000_1230, ready=1 at once, one beat 128'hA5.. → mem_cmd_addr=28'h000_0123, write=0; ic_rdat_m_valid and ic_finish_mrd both 1 one cycle after mem_rdata_valid; rdat_m_valid stays 0.
- dcw, dcr and icr pulses in the same cycle → commands issued in order write, D-read, I-read. rqfull_1 is 1 until the dcr grant. dcw_finish_wresp fires before the dcr command.
- RBEATS=4, dcr read → four rdat_m_valid pulses; finish_mrd only with the 4th; state IDLE afterwards.
- mem_cmd_ready held 0 for 10 cycles → mem_cmd_valid, addr, wdata and wmask stay stable; a new icr pulse during the stall is only pending.
- rst asserted during RDATA after beat 1 of 2 → all outputs at reset values next cycle; a later stray mem_rdata_valid produces no output valid.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and widths for the cache-refill memory request arbiter.
// Holds FSM state encodings, source IDs and the buffered write payload layout.
package mem_req_arbiter_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_OFS_W = 4;
    localparam int unsigned LINE_W     = ADDR_W - LINE_OFS_W;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned MASK_W     = DATA_W / 8;
    localparam int unsigned BEAT_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RDATA = 2'd2,
        WRESP = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_IC = 2'd0,
        SRC_DR = 2'd1,
        SRC_DW = 2'd2
    } src_e;

    // Payload captured by the D-cache write slot.
    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    localparam int unsigned WR_REQ_W = LINE_W + MASK_W + DATA_W;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Single 128-bit memory command/response port shared by all cache requesters.
// master = arbiter side, slave = memory controller side.
interface mem_req_arbiter_if;
    import mem_req_arbiter_pkg::*;

    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_write;
    logic [LINE_W-1:0] mem_cmd_addr;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;
    logic              mem_wresp_valid;

    modport master (
        output mem_cmd_valid,
        input  mem_cmd_ready,
        output mem_cmd_write,
        output mem_cmd_addr,
        output mem_wmask,
        output mem_wdata,
        input  mem_rdata,
        input  mem_rdata_valid,
        input  mem_wresp_valid
    );

    modport slave (
        input  mem_cmd_valid,
        output mem_cmd_ready,
        input  mem_cmd_write,
        input  mem_cmd_addr,
        input  mem_wmask,
        input  mem_wdata,
        output mem_rdata,
        output mem_rdata_valid,
        output mem_wresp_valid
    );

endinterface

// File: rtl/arb_req_slot.sv
// Pulse-capture request slot: latches the payload on a start pulse and holds
// a pending flag until granted. Pulses into an already-pending slot are ignored.
module arb_req_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         grant,
    input  logic [W-1:0] din,
    output logic         pend,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            q    <= '0;
        end else if (grant) begin
            pend <= 1'b0;
        end else if (start && !pend) begin
            pend <= 1'b1;
            q    <= din;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Serializes I-cache reads, D-cache reads and D-cache writes onto one memory
// command port (priority dcw > dcr > icr) and routes returns to the requester.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned RBEATS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icr_start_rq,
    input  logic [ADDR_W-1:0] ic_rin_addr,
    output logic [DATA_W-1:0] ic_rdat_m_data,
    output logic [MASK_W-1:0] ic_rdat_m_mask,
    output logic              ic_rdat_m_valid,
    output logic              ic_finish_mrd,
    input  logic              dcr_start_rq,
    input  logic [ADDR_W-1:0] dcr_rin_addr,
    output logic [DATA_W-1:0] rdat_m_data,
    output logic              rdat_m_valid,
    output logic              finish_mrd,
    input  logic              dcw_start_rq,
    input  logic [ADDR_W-1:0] dcw_in_addr,
    input  logic [MASK_W-1:0] dcw_in_mask,
    input  logic [DATA_W-1:0] dcw_in_data,
    output logic              dcw_finish_wresp,
    output logic              rqfull_1,
    mem_req_arbiter_if.master mem
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(RBEATS - 1);

    arb_state_e            state, state_nxt;
    src_e                  src, src_nxt;
    logic [BEAT_CNT_W-1:0] beat_cnt, beat_cnt_nxt;

    logic              pend_ic, pend_dr, pend_dw;
    logic              grant_ic, grant_dr, grant_dw;
    logic [LINE_W-1:0] ic_line, dr_line;
    wr_req_t           dw_din, dw_req;

    logic              cmd_valid_nxt, cmd_write_nxt;
    logic [LINE_W-1:0] cmd_addr_nxt;
    logic [MASK_W-1:0] wmask_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              ic_valid_nxt, ic_fin_nxt, dr_valid_nxt, dr_fin_nxt;
    logic [DATA_W-1:0] ic_data_nxt, dr_data_nxt;
    logic              wresp_fin_nxt, rqfull_nxt;

    // Byte offset within a line is meaningless to the line-granular memory port.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{ic_rin_addr[LINE_OFS_W-1:0],
                               dcr_rin_addr[LINE_OFS_W-1:0],
                               dcw_in_addr[LINE_OFS_W-1:0]};

    assign ic_rdat_m_mask = '1;

    assign dw_din = '{line: dcw_in_addr[ADDR_W-1:LINE_OFS_W],
                      mask: dcw_in_mask,
                      data: dcw_in_data};

    arb_req_slot #(.W(LINE_W)) u_slot_ic (
        .clk   (clk),
        .rst   (rst),
        .start (icr_start_rq),
        .grant (grant_ic),
        .din   (ic_rin_addr[ADDR_W-1:LINE_OFS_W]),
        .pend  (pend_ic),
        .q     (ic_line)
    );

    arb_req_slot #(.W(LINE_W)) u_slot_dr (
        .clk   (clk),
        .rst   (rst),
        .start (dcr_start_rq),
        .grant (grant_dr),
        .din   (dcr_rin_addr[ADDR_W-1:LINE_OFS_W]),
        .pend  (pend_dr),
        .q     (dr_line)
    );

    arb_req_slot #(.W(WR_REQ_W)) u_slot_dw (
        .clk   (clk),
        .rst   (rst),
        .start (dcw_start_rq),
        .grant (grant_dw),
        .din   (dw_din),
        .pend  (pend_dw),
        .q     (dw_req)
    );

    // Next-state, grant and registered-output computation.
    always_comb begin
        state_nxt     = state;
        src_nxt       = src;
        beat_cnt_nxt  = beat_cnt;
        grant_ic      = 1'b0;
        grant_dr      = 1'b0;
        grant_dw      = 1'b0;
        cmd_valid_nxt = mem.mem_cmd_valid;
        cmd_write_nxt = mem.mem_cmd_write;
        cmd_addr_nxt  = mem.mem_cmd_addr;
        wmask_nxt     = mem.mem_wmask;
        wdata_nxt     = mem.mem_wdata;
        ic_valid_nxt  = 1'b0;
        ic_fin_nxt    = 1'b0;
        ic_data_nxt   = ic_rdat_m_data;
        dr_valid_nxt  = 1'b0;
        dr_fin_nxt    = 1'b0;
        dr_data_nxt   = rdat_m_data;
        wresp_fin_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (pend_dw) begin
                    grant_dw      = 1'b1;
                    src_nxt       = SRC_DW;
                    cmd_write_nxt = 1'b1;
                    cmd_addr_nxt  = dw_req.line;
                    wmask_nxt     = dw_req.mask;
                    wdata_nxt     = dw_req.data;
                end else if (pend_dr) begin
                    grant_dr      = 1'b1;
                    src_nxt       = SRC_DR;
                    cmd_write_nxt = 1'b0;
                    cmd_addr_nxt  = dr_line;
                    wmask_nxt     = '0;
                    wdata_nxt     = '0;
                end else if (pend_ic) begin
                    grant_ic      = 1'b1;
                    src_nxt       = SRC_IC;
                    cmd_write_nxt = 1'b0;
                    cmd_addr_nxt  = ic_line;
                    wmask_nxt     = '0;
                    wdata_nxt     = '0;
                end
                if (pend_dw || pend_dr || pend_ic) begin
                    cmd_valid_nxt = 1'b1;
                    state_nxt     = CMD;
                end
            end
            CMD: begin
                if (mem.mem_cmd_valid && mem.mem_cmd_ready) begin
                    cmd_valid_nxt = 1'b0;
                    beat_cnt_nxt  = '0;
                    state_nxt     = (src == SRC_DW) ? WRESP : RDATA;
                end
            end
            RDATA: begin
                if (mem.mem_rdata_valid) begin
                    if (src == SRC_IC) begin
                        ic_valid_nxt = 1'b1;
                        ic_fin_nxt   = (beat_cnt == LAST_BEAT);
                        ic_data_nxt  = mem.mem_rdata;
                    end else begin
                        dr_valid_nxt = 1'b1;
                        dr_fin_nxt   = (beat_cnt == LAST_BEAT);
                        dr_data_nxt  = mem.mem_rdata;
                    end
                    beat_cnt_nxt = beat_cnt + BEAT_CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WRESP: begin
                if (mem.mem_wresp_valid) begin
                    wresp_fin_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Mirrors the data-side slot pend flags one edge ahead so rqfull_1 is a flop.
        rqfull_nxt = (grant_dr ? 1'b0 : (pend_dr | dcr_start_rq)) |
                     (grant_dw ? 1'b0 : (pend_dw | dcw_start_rq));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            src               <= SRC_IC;
            beat_cnt          <= '0;
            mem.mem_cmd_valid <= 1'b0;
            mem.mem_cmd_write <= 1'b0;
            mem.mem_cmd_addr  <= '0;
            mem.mem_wmask     <= '0;
            mem.mem_wdata     <= '0;
            ic_rdat_m_valid   <= 1'b0;
            ic_finish_mrd     <= 1'b0;
            ic_rdat_m_data    <= '0;
            rdat_m_valid      <= 1'b0;
            finish_mrd        <= 1'b0;
            rdat_m_data       <= '0;
            dcw_finish_wresp  <= 1'b0;
            rqfull_1          <= 1'b0;
        end else begin
            state             <= state_nxt;
            src               <= src_nxt;
            beat_cnt          <= beat_cnt_nxt;
            mem.mem_cmd_valid <= cmd_valid_nxt;
            mem.mem_cmd_write <= cmd_write_nxt;
            mem.mem_cmd_addr  <= cmd_addr_nxt;
            mem.mem_wmask     <= wmask_nxt;
            mem.mem_wdata     <= wdata_nxt;
            ic_rdat_m_valid   <= ic_valid_nxt;
            ic_finish_mrd     <= ic_fin_nxt;
            ic_rdat_m_data    <= ic_data_nxt;
            rdat_m_valid      <= dr_valid_nxt;
            finish_mrd        <= dr_fin_nxt;
            rdat_m_data       <= dr_data_nxt;
            dcw_finish_wresp  <= wresp_fin_nxt;
            rqfull_1          <= rqfull_nxt;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int unsigned RBEATS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         icr_start_rq, dcr_start_rq, dcw_start_rq;
    logic [31:0]  ic_rin_addr, dcr_rin_addr, dcw_in_addr;
    logic [15:0]  dcw_in_mask;
    logic [127:0] dcw_in_data;
    logic [127:0] ic_rdat_m_data, rdat_m_data;
    logic [15:0]  ic_rdat_m_mask;
    logic         ic_rdat_m_valid, ic_finish_mrd, rdat_m_valid, finish_mrd;
    logic         dcw_finish_wresp, rqfull_1;

    mem_req_arbiter_if mif ();

    mem_req_arbiter #(.RBEATS(RBEATS)) dut (
        .clk              (clk),
        .rst              (rst),
        .icr_start_rq     (icr_start_rq),
        .ic_rin_addr      (ic_rin_addr),
        .ic_rdat_m_data   (ic_rdat_m_data),
        .ic_rdat_m_mask   (ic_rdat_m_mask),
        .ic_rdat_m_valid  (ic_rdat_m_valid),
        .ic_finish_mrd    (ic_finish_mrd),
        .dcr_start_rq     (dcr_start_rq),
        .dcr_rin_addr     (dcr_rin_addr),
        .rdat_m_data      (rdat_m_data),
        .rdat_m_valid     (rdat_m_valid),
        .finish_mrd       (finish_mrd),
        .dcw_start_rq     (dcw_start_rq),
        .dcw_in_addr      (dcw_in_addr),
        .dcw_in_mask      (dcw_in_mask),
        .dcw_in_data      (dcw_in_data),
        .dcw_finish_wresp (dcw_finish_wresp),
        .rqfull_1         (rqfull_1),
        .mem              (mif)
    );

    int errors = 0;
    int checks = 0;

    // Model: slot index 0 = I-read, 1 = D-read, 2 = D-write; phase 0 idle, 1 command, 2 response.
    bit           m_pend [3];
    logic [27:0]  m_addr [3];
    logic [15:0]  m_mask;
    logic [127:0] m_wdata;
    int           m_phase, m_src, m_beats;
    bit           e_valid, e_write;
    logic [27:0]  e_addr;
    logic [15:0]  e_mask;
    logic [127:0] e_wdata, e_rdata;
    bit           e_ic_v, e_ic_fin, e_dr_v, e_dr_fin, e_wr_fin;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit start [3];
        int g;
        start[0] = icr_start_rq;
        start[1] = dcr_start_rq;
        start[2] = dcw_start_rq;
        e_ic_v = 0; e_ic_fin = 0; e_dr_v = 0; e_dr_fin = 0; e_wr_fin = 0;
        for (int s = 0; s < 3; s++) chk("no_dup_pulse", 1'(start[s] && m_pend[s]), 1'b0);
        if (rst) begin
            for (int s = 0; s < 3; s++) m_pend[s] = 0;
            m_phase = 0; e_valid = 0; e_write = 0; e_addr = '0; e_mask = '0; e_wdata = '0;
            return;
        end
        g = -1;
        if (m_phase == 0)
            for (int s = 2; s >= 0; s--) if (m_pend[s] && g < 0) g = s;
        if (m_phase == 1 && mif.mem_cmd_ready) begin
            m_phase = 2; m_beats = 0; e_valid = 0;
        end else if (m_phase == 2 && m_src != 2 && mif.mem_rdata_valid) begin
            m_beats++;
            e_rdata = mif.mem_rdata;
            if (m_src == 0) begin e_ic_v = 1; e_ic_fin = (m_beats == int'(RBEATS)); end
            else            begin e_dr_v = 1; e_dr_fin = (m_beats == int'(RBEATS)); end
            if (m_beats == int'(RBEATS)) m_phase = 0;
        end else if (m_phase == 2 && m_src == 2 && mif.mem_wresp_valid) begin
            e_wr_fin = 1; m_phase = 0;
        end
        if (start[0] && !m_pend[0]) begin m_pend[0] = 1; m_addr[0] = ic_rin_addr[31:4]; end
        if (start[1] && !m_pend[1]) begin m_pend[1] = 1; m_addr[1] = dcr_rin_addr[31:4]; end
        if (start[2] && !m_pend[2]) begin
            m_pend[2] = 1; m_addr[2] = dcw_in_addr[31:4]; m_mask = dcw_in_mask; m_wdata = dcw_in_data;
        end
        if (g >= 0) begin
            m_pend[g] = 0; m_src = g; m_phase = 1;
            e_valid = 1; e_write = (g == 2); e_addr = m_addr[g];
            e_mask  = (g == 2) ? m_mask : 16'h0;
            e_wdata = (g == 2) ? m_wdata : 128'h0;
        end
    endtask

    task automatic check_outputs();
        chk("cmd_valid", mif.mem_cmd_valid, e_valid);
        if (e_valid) begin
            chk("cmd_write", mif.mem_cmd_write, e_write);
            chk("cmd_addr", mif.mem_cmd_addr, e_addr);
            chk("cmd_wmask", mif.mem_wmask, e_mask);
            chk("cmd_wdata", mif.mem_wdata, e_wdata);
        end
        chk("rqfull_1", rqfull_1, 1'(m_pend[1] | m_pend[2]));
        chk("ic_valid", ic_rdat_m_valid, e_ic_v);
        chk("ic_finish", ic_finish_mrd, e_ic_fin);
        chk("dr_valid", rdat_m_valid, e_dr_v);
        chk("dr_finish", finish_mrd, e_dr_fin);
        chk("wr_finish", dcw_finish_wresp, e_wr_fin);
        chk("ic_mask", ic_rdat_m_mask, 16'hffff);
        if (e_ic_v) chk("ic_data", ic_rdat_m_data, e_rdata);
        if (e_dr_v) chk("dr_data", rdat_m_data, e_rdata);
    endtask

    // One clock: model sees the inputs at the edge, outputs are checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        icr_start_rq = 0; dcr_start_rq = 0; dcw_start_rq = 0;
        mif.mem_rdata_valid = 0; mif.mem_wresp_valid = 0;
        check_outputs();
    endtask

    task automatic send_beats(input string tag, input bit to_ic);
        logic [127:0] d;
        for (int b = 0; b < int'(RBEATS); b++) begin
            d = {16{8'hA5}} ^ 128'(b);
            mif.mem_rdata = d; mif.mem_rdata_valid = 1;
            tick();
            chk({tag, "_icv"}, ic_rdat_m_valid, to_ic);
            chk({tag, "_drv"}, rdat_m_valid, !to_ic);
            chk({tag, "_fin"}, to_ic ? ic_finish_mrd : finish_mrd, 1'(b == int'(RBEATS) - 1));
            chk({tag, "_data"}, to_ic ? ic_rdat_m_data : rdat_m_data, d);
        end
    endtask

    initial begin
        rst = 1;
        icr_start_rq = 0; dcr_start_rq = 0; dcw_start_rq = 0;
        ic_rin_addr = '0; dcr_rin_addr = '0; dcw_in_addr = '0; dcw_in_mask = '0; dcw_in_data = '0;
        mif.mem_cmd_ready = 0; mif.mem_rdata = '0; mif.mem_rdata_valid = 0; mif.mem_wresp_valid = 0;
        for (int s = 0; s < 3; s++) begin m_pend[s] = 0; m_addr[s] = '0; end
        m_phase = 0; m_src = 0; m_beats = 0; m_mask = '0; m_wdata = '0;
        e_valid = 0; e_write = 0; e_addr = '0; e_mask = '0; e_wdata = '0; e_rdata = '0;
        e_ic_v = 0; e_ic_fin = 0; e_dr_v = 0; e_dr_fin = 0; e_wr_fin = 0;

        // Reset values
        tick(); tick();
        chk("rst_write", mif.mem_cmd_write, 1'b0);
        chk("rst_addr", mif.mem_cmd_addr, 28'h0);
        chk("rst_wmask", mif.mem_wmask, 16'h0);
        chk("rst_wdata", mif.mem_wdata, 128'h0);
        chk("rst_icdata", ic_rdat_m_data, 128'h0);
        chk("rst_drdata", rdat_m_data, 128'h0);
        rst = 0;
        tick();

        // Single I-cache read with immediate ready
        mif.mem_cmd_ready = 1;
        ic_rin_addr = 32'h0000_1230; icr_start_rq = 1;
        tick();
        chk("d1_no_cmd_yet", mif.mem_cmd_valid, 1'b0);
        tick();
        chk("d1_valid", mif.mem_cmd_valid, 1'b1);
        chk("d1_addr", mif.mem_cmd_addr, 28'h000_0123);
        chk("d1_write", mif.mem_cmd_write, 1'b0);
        tick();
        send_beats("d1", 1'b1);
        tick();

        // Simultaneous requests: write, then D-read, then I-read
        dcw_in_addr = 32'h0000_ABC8; dcw_in_mask = 16'h0F0F; dcw_in_data = {4{32'hDEAD_BEEF}};
        dcr_rin_addr = 32'h0000_2220; ic_rin_addr = 32'h0000_3330;
        dcw_start_rq = 1; dcr_start_rq = 1; icr_start_rq = 1;
        tick();
        chk("d2_rqfull_pend", rqfull_1, 1'b1);
        tick();
        chk("d2_w_write", mif.mem_cmd_write, 1'b1);
        chk("d2_w_addr", mif.mem_cmd_addr, 28'h000_0ABC);
        chk("d2_w_mask", mif.mem_wmask, 16'h0F0F);
        chk("d2_rqfull_w", rqfull_1, 1'b1);
        tick();
        mif.mem_wresp_valid = 1;
        tick();
        chk("d2_wresp", dcw_finish_wresp, 1'b1);
        chk("d2_no_cmd", mif.mem_cmd_valid, 1'b0);
        tick();
        chk("d2_r_valid", mif.mem_cmd_valid, 1'b1);
        chk("d2_r_write", mif.mem_cmd_write, 1'b0);
        chk("d2_r_addr", mif.mem_cmd_addr, 28'h000_0222);
        chk("d2_rqfull_clr", rqfull_1, 1'b0);
        tick();
        send_beats("d2r", 1'b0);
        tick();
        chk("d2_i_addr", mif.mem_cmd_addr, 28'h000_0333);
        tick();
        send_beats("d2i", 1'b1);
        tick();

        // Command stall: fields hold, new I-read only pends
        mif.mem_cmd_ready = 0;
        dcw_in_addr = 32'h0001_0000; dcw_in_mask = 16'h8001; dcw_in_data = {4{32'h1234_5678}};
        dcw_start_rq = 1;
        tick(); tick();
        ic_rin_addr = 32'h0000_4440; icr_start_rq = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("d3_valid", mif.mem_cmd_valid, 1'b1);
            chk("d3_write", mif.mem_cmd_write, 1'b1);
            chk("d3_addr", mif.mem_cmd_addr, 28'h000_1000);
            chk("d3_wmask", mif.mem_wmask, 16'h8001);
            chk("d3_wdata", mif.mem_wdata, {4{32'h1234_5678}});
        end
        mif.mem_cmd_ready = 1;
        tick();
        mif.mem_wresp_valid = 1;
        tick(); tick();
        chk("d3_i_after", mif.mem_cmd_addr, 28'h000_0444);
        tick();
        send_beats("d3i", 1'b1);
        tick();

        // Reset in the middle of a read burst
        dcr_rin_addr = 32'h0000_5550; dcr_start_rq = 1;
        tick(); tick(); tick();
        mif.mem_rdata = 128'h77; mif.mem_rdata_valid = 1;
        tick();
        chk("d4_beat1", rdat_m_valid, 1'b1);
        rst = 1;
        tick();
        chk("d4_rst_valid", rdat_m_valid, 1'b0);
        chk("d4_rst_data", rdat_m_data, 128'h0);
        chk("d4_rst_cmd", mif.mem_cmd_valid, 1'b0);
        chk("d4_rst_addr", mif.mem_cmd_addr, 28'h0);
        rst = 0;
        mif.mem_rdata_valid = 1;
        tick();
        chk("d4_stray", rdat_m_valid, 1'b0);
        chk("d4_stray_fin", finish_mrd, 1'b0);
        tick();

        // Random traffic with random backpressure, stray responses and occasional reset
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 3) == 0 && !m_pend[0]) begin
                icr_start_rq = 1; ic_rin_addr = $urandom;
            end
            if ($urandom_range(0, 4) == 0 && !m_pend[1]) begin
                dcr_start_rq = 1; dcr_rin_addr = $urandom;
            end
            if ($urandom_range(0, 5) == 0 && !m_pend[2]) begin
                dcw_start_rq = 1; dcw_in_addr = $urandom; dcw_in_mask = 16'($urandom);
                dcw_in_data = {$urandom, $urandom, $urandom, $urandom};
            end
            mif.mem_cmd_ready   = ($urandom_range(0, 2) != 0);
            mif.mem_rdata       = {$urandom, $urandom, $urandom, $urandom};
            mif.mem_rdata_valid = ($urandom_range(0, 2) == 0);
            mif.mem_wresp_valid = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
